// File: rtl/mux_bus_pkg.sv
// -----------------------------------------------------------------------------
// mux_bus_pkg
// Shared constants and helpers for the mux_bus_arb channel multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the Mode input
//   clog2()              : constant ceiling-log2, usable in parameter math
// -----------------------------------------------------------------------------
package mux_bus_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for elaboration-time width calculations (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_bus_rr_arbiter
// Round-robin search plus the rotating pointer it starts from.
// The search begins at pointer+1 and wraps past NrOfInputs-1 back to 0, so the
// channel served last gets the lowest priority next time. When i_lock is high
// only the pointer channel may be granted.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointer -> N-1)
//   i_req          : per-channel request vector
//   i_lock         : restrict grant to the pointer channel
//   i_update       : load pointer with the current grant (round-robin transfer)
//   o_grant        : granted channel index (combinational)
//   o_grant_vld    : a channel is granted (combinational)
// -----------------------------------------------------------------------------
module mux_bus_rr_arbiter
    import mux_bus_pkg::*;
#(
    parameter int NrOfInputs = 4,
    parameter int SelBits    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NrOfInputs-1:0] i_req,
    input  logic                  i_lock,
    input  logic                  i_update,
    output logic [SelBits-1:0]    o_grant,
    output logic                  o_grant_vld
);

    // One extra bit so pointer+1+offset (at most 2*N-1) never overflows.
    localparam int SumW = SelBits + 1;

    logic [SelBits-1:0]      r_ptr;
    logic [SumW-1:0]         w_start;
    logic [2*NrOfInputs-1:0] w_req2;
    logic [2*NrOfInputs-1:0] w_rot;
    logic [SelBits-1:0]      w_off;
    logic                    w_any;
    logic [SumW-1:0]         w_sum;
    logic                    w_ptr_req;

    // Rotate the doubled request vector so bit 0 is pointer+1, then take the
    // lowest set bit; doubling makes the wrap-around free.
    always_comb begin
        w_start   = {1'b0, r_ptr} + SumW'(1);
        w_req2    = {i_req, i_req};
        w_rot     = w_req2 >> w_start;
        w_off     = '0;
        w_any     = 1'b0;
        w_ptr_req = 1'b0;
        for (int i = NrOfInputs - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? SelBits'(i) : w_off;
            w_any = w_any | w_rot[i];
        end
        for (int i = 0; i < NrOfInputs; i++) begin
            w_ptr_req = w_ptr_req | (i_req[i] & (r_ptr == SelBits'(i)));
        end
        w_sum = w_start + SumW'(w_off);
        w_sum = (w_sum >= SumW'(NrOfInputs)) ? (w_sum - SumW'(NrOfInputs)) : w_sum;
        if (i_lock) begin
            o_grant     = r_ptr;
            o_grant_vld = w_ptr_req;
        end else begin
            o_grant     = w_sum[SelBits-1:0];
            o_grant_vld = w_any;
        end
    end

    // Pointer follows the last round-robin winner; reset value makes channel 0
    // the first choice.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= SelBits'(NrOfInputs - 1);
        end else if (i_update) begin
            r_ptr <= o_grant;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/mux_bus_arb.sv
// -----------------------------------------------------------------------------
// mux_bus_arb
// N-channel valid/ready multiplexer with a single output register. A channel is
// granted either by Sel (Mode=0) or round-robin (Mode=1); the granted channel's
// word is loaded into MuxOut one cycle after its InValid/InReady handshake.
// Optional feature macro: MUX_BUS_ARB_LOCK_EN adds the Lock input, which pins
// round-robin grants to the last winner while its lock flag is set.
// Ports:
//   Clock, nReset : clock, asynchronous active-low reset
//   Enable        : permit new loads (draining is never blocked)
//   Mode, Sel     : grant mode and fixed-mode channel index
//   MuxIn         : channel i at [i*NrOfBits +: NrOfBits]
//   InValid       : per-channel valid
//   Lock          : (MUX_BUS_ARB_LOCK_EN only) hold grant on this channel
//   InReady       : per-channel accept, combinational, one-hot or zero
//   MuxOut        : registered selected data
//   OutValid      : MuxOut holds an unconsumed word
//   OutReady      : downstream accepts MuxOut
//   OutSel        : channel index that produced MuxOut
// -----------------------------------------------------------------------------
module mux_bus_arb
    import mux_bus_pkg::*;
#(
    parameter int NrOfBits   = 8,
    parameter int NrOfInputs = 4,
    parameter int SelBits    = 2
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic                           Enable,
    input  logic                           Mode,
    input  logic [SelBits-1:0]             Sel,
    input  logic [NrOfInputs*NrOfBits-1:0] MuxIn,
    input  logic [NrOfInputs-1:0]          InValid,
`ifdef MUX_BUS_ARB_LOCK_EN
    input  logic                           Lock,
`endif
    output logic [NrOfInputs-1:0]          InReady,
    output logic [NrOfBits-1:0]            MuxOut,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [SelBits-1:0]             OutSel
);

    logic [NrOfBits-1:0] r_mux_out;
    logic                r_out_valid;
    logic [SelBits-1:0]  r_out_sel;

    logic                w_can_load;
    logic                w_lock;
    logic [SelBits-1:0]  w_rr_grant;
    logic                w_rr_vld;
    logic                w_fix_vld;
    logic [SelBits-1:0]  w_grant;
    logic                w_grant_vld;
    logic                w_xfer;
    logic                w_rr_update;
    logic [NrOfBits-1:0] w_data;

`ifdef MUX_BUS_ARB_LOCK_EN
    logic r_lock;

    // Lock flag follows the Lock input sampled on each round-robin transfer.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_lock <= 1'b0;
        end else if (w_rr_update) begin
            r_lock <= Lock;
        end else begin
            r_lock <= r_lock;
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Register is free if empty or being drained this cycle.
    assign w_can_load = ~r_out_valid | OutReady;

    mux_bus_rr_arbiter #(
        .NrOfInputs (NrOfInputs),
        .SelBits    (SelBits)
    ) u_rr_arbiter (
        .i_clk       (Clock),
        .i_rst_n     (nReset),
        .i_req       (InValid),
        .i_lock      (w_lock),
        .i_update    (w_rr_update),
        .o_grant     (w_rr_grant),
        .o_grant_vld (w_rr_vld)
    );

    // Grant selection; fixed mode only grants a requesting channel, and an
    // out-of-range Sel matches no channel so nothing is granted.
    always_comb begin
        w_fix_vld = 1'b0;
        for (int i = 0; i < NrOfInputs; i++) begin
            w_fix_vld = w_fix_vld | (InValid[i] & (Sel == SelBits'(i)));
        end
        if (Mode == MODE_RR) begin
            w_grant     = w_rr_grant;
            w_grant_vld = w_rr_vld;
        end else begin
            w_grant     = Sel;
            w_grant_vld = w_fix_vld;
        end
    end

    // One-hot ready decode and data select for the granted channel.
    always_comb begin
        InReady = '0;
        w_data  = '0;
        for (int i = 0; i < NrOfInputs; i++) begin
            InReady[i] = Enable & w_can_load & w_grant_vld & (w_grant == SelBits'(i));
            w_data     = (w_grant == SelBits'(i)) ? MuxIn[i*NrOfBits +: NrOfBits] : w_data;
        end
    end

    assign w_xfer      = |(InValid & InReady);
    assign w_rr_update = w_xfer & (Mode == MODE_RR);

    // Output register: load wins over drain, so back-to-back words keep
    // OutValid high.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_mux_out   <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_mux_out   <= w_data;
            r_out_sel   <= w_grant;
            r_out_valid <= 1'b1;
        end else if (OutReady) begin
            r_mux_out   <= r_mux_out;
            r_out_sel   <= r_out_sel;
            r_out_valid <= 1'b0;
        end else begin
            r_mux_out   <= r_mux_out;
            r_out_sel   <= r_out_sel;
            r_out_valid <= r_out_valid;
        end
    end

    assign MuxOut   = r_mux_out;
    assign OutValid = r_out_valid;
    assign OutSel   = r_out_sel;

endmodule
